// File: rtl/mux_scan_pkg.sv
// Shared constants and helpers for the registered scanning multiplexer.
package mux_scan_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_if.sv
// Channel-side inputs and consumer-side handshake of the scanning multiplexer.
interface mux_scan_if
  import mux_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 4
);
  localparam int SELW = clog2(CH);

  logic [CH*WIDTH-1:0] din;
  logic [CH-1:0]       ch_valid;
  logic                mode;
  logic [SELW-1:0]     sel;
  logic [CH-1:0]       mask;
  logic [WIDTH-1:0]    out_data;
  logic [SELW-1:0]     out_ch;
  logic                out_valid;
  logic                out_ready;
  logic                drop;

  modport master (
    output din, ch_valid, mode, sel, mask, out_ready,
    input  out_data, out_ch, out_valid, drop
  );

  modport slave (
    input  din, ch_valid, mode, sel, mask, out_ready,
    output out_data, out_ch, out_valid, drop
  );

endinterface

// File: rtl/mux_scan_next.sv
// Finds the next enabled channel strictly after ptr, wrapping; a lone enabled
// ptr maps back onto itself because the search ends at offset CH.
module mux_scan_next
  import mux_scan_pkg::*;
#(
  parameter int CH   = 4,
  parameter int SELW = clog2(CH)
) (
  input  logic [SELW-1:0] ptr,
  input  logic [CH-1:0]   mask,
  output logic [SELW-1:0] nxt,
  output logic            any
);

  logic [SELW-1:0] idx;
  logic            found;

  always_comb begin
    nxt   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int i = 1; i <= CH; i++) begin
      idx = ptr + SELW'(i);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  assign any = |mask;

endmodule

// File: rtl/mux_scan.sv
// Registered N:1 multiplexer with direct-select and round-robin scan modes,
// a one-deep valid/ready output slot and a drop flag for lost samples.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int DWELL = 4
) (
  input logic      clk,
  input logic      rst_n,
  mux_scan_if.slave bus
);

  localparam int SELW = clog2(CH);
  localparam int DW   = (DWELL > 1) ? clog2(DWELL) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);

  logic [SELW-1:0]  ptr;
  logic [DW-1:0]    dcnt;
  logic [WIDTH-1:0] out_data_r;
  logic [SELW-1:0]  out_ch_r;
  logic             out_valid_r;
  logic             drop_r;

  logic [SELW-1:0]  nxt;
  logic             any;
  logic [WIDTH-1:0] ch_data;
  logic             qualify;
  logic             slot_free;

  mux_scan_next #(.CH(CH), .SELW(SELW)) u_next (
    .ptr  (ptr),
    .mask (bus.mask),
    .nxt  (nxt),
    .any  (any)
  );

  always_comb begin
    ch_data = '0;
    for (int k = 0; k < CH; k++) begin
      if (ptr == SELW'(k)) ch_data = bus.din[k*WIDTH +: WIDTH];
    end
  end

  // In scan mode a masked channel is never sampled, even while the pointer
  // still rests on it after a mode switch.
  assign qualify   = bus.ch_valid[ptr] && ((bus.mode == MODE_DIRECT) || bus.mask[ptr]);
  assign slot_free = !out_valid_r || bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr         <= '0;
      dcnt        <= '0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
      out_valid_r <= 1'b0;
      drop_r      <= 1'b0;
    end else begin
      drop_r <= 1'b0;

      if (bus.mode == MODE_DIRECT) begin
        ptr  <= bus.sel;
        dcnt <= '0;
      end else if (dcnt == DLAST) begin
        dcnt <= '0;
        if (any) ptr <= nxt;
      end else begin
        dcnt <= dcnt + DW'(1);
      end

      if (slot_free) begin
        if (qualify) begin
          out_data_r  <= ch_data;
          out_ch_r    <= ptr;
          out_valid_r <= 1'b1;
        end else begin
          out_valid_r <= 1'b0;
        end
      end else if (qualify) begin
        drop_r <= 1'b1;
      end
    end
  end

  assign bus.out_data  = out_data_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.out_valid = out_valid_r;
  assign bus.drop      = drop_r;

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan: direct select, stall/drop, scan order,
// empty mask, masked start channel and reset during a stall.
module tb_mux_scan;
  import mux_scan_pkg::*;

  localparam int WIDTH = 8;
  localparam int CH    = 4;
  localparam int DWELL = 4;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mux_scan_if #(.WIDTH(WIDTH), .CH(CH)) bus ();

  mux_scan #(.WIDTH(WIDTH), .CH(CH), .DWELL(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [31:0] DIN_BASE = {8'h44, 8'h33, 8'h22, 8'h11};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s observed=empty_queue expected=sample", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_ch"},    32'(bus.out_ch),    32'(e.ch));
      chk({tag, "_data"},  32'(bus.out_data),  32'(e.data));
    end
  endtask

  task automatic push(input logic [1:0] ch, input logic [7:0] data);
    exp_t e;
    e.ch   = ch;
    e.data = data;
    exp_q.push_back(e);
  endtask

  initial begin
    bus.din       = DIN_BASE;
    bus.ch_valid  = 4'hF;
    bus.mode      = MODE_DIRECT;
    bus.sel       = 2'd0;
    bus.mask      = 4'h0;
    bus.out_ready = 1'b1;

    // reset state
    step();
    step();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data",  32'(bus.out_data),  32'd0);
    chk("rst_ch",    32'(bus.out_ch),    32'd0);
    chk("rst_drop",  32'(bus.drop),      32'd0);

    // direct mode: pointer follows sel one edge later
    rst_n   = 1'b1;
    bus.sel = 2'd2;
    push(2'd0, 8'h11);
    step();
    pop_chk("dir_first");
    push(2'd2, 8'h33);
    step();
    pop_chk("dir_sel2");
    push(2'd2, 8'h33);
    step();
    pop_chk("dir_thru");

    bus.ch_valid = 4'b1011;
    step();
    chk("dir_invalid_valid", 32'(bus.out_valid), 32'd0);

    // stall: first sample frozen, later ones dropped
    bus.ch_valid  = 4'hF;
    bus.out_ready = 1'b0;
    step();
    chk("stall0_data", 32'(bus.out_data), 32'h33);
    chk("stall0_drop", 32'(bus.drop),     32'd0);
    bus.din[23:16] = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_data",  32'(bus.out_data),  32'h33);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_drop",  32'(bus.drop),      32'd1);
    end
    bus.out_ready = 1'b1;
    push(2'd2, 8'h5A);
    step();
    pop_chk("stall_release");
    chk("release_drop", 32'(bus.drop), 32'd0);

    // scan mask 1011 from channel 0
    bus.din  = DIN_BASE;
    bus.sel  = 2'd0;
    bus.mask = 4'b1011;
    step();
    bus.mode = MODE_SCAN;
    for (int i = 0; i < 4; i++) push(2'd0, 8'h11);
    for (int i = 0; i < 4; i++) push(2'd1, 8'h22);
    for (int i = 0; i < 4; i++) push(2'd3, 8'h44);
    for (int i = 0; i < 4; i++) push(2'd0, 8'h11);
    for (int i = 0; i < 16; i++) begin
      step();
      pop_chk("scan");
    end

    // empty mask: nothing captured, pointer parked
    bus.mode = MODE_DIRECT;
    bus.sel  = 2'd1;
    step();
    bus.mode = MODE_SCAN;
    bus.mask = 4'h0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("mask0_valid", 32'(bus.out_valid), 32'd0);
      chk("mask0_drop",  32'(bus.drop),      32'd0);
      chk("mask0_ptr",   32'(dut.ptr),       32'd1);
    end

    // switch to scan on a masked start channel
    bus.mode     = MODE_DIRECT;
    bus.sel      = 2'd3;
    bus.ch_valid = 4'h0;
    bus.mask     = 4'b0111;
    step();
    step();
    bus.mode     = MODE_SCAN;
    bus.ch_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mstart_valid", 32'(bus.out_valid), 32'd0);
    end
    push(2'd0, 8'h11);
    step();
    pop_chk("mstart_first");

    // stall while scanning, then reset in the middle of it
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sstall_data", 32'(bus.out_data), 32'h11);
      chk("sstall_drop", 32'(bus.drop),     32'd1);
    end
    chk("pre_rst_ptr",  32'(dut.ptr),  32'd1);
    chk("pre_rst_dcnt", 32'(dut.dcnt), 32'd1);
    rst_n = 1'b0;
    step();
    chk("mrst_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_data",  32'(bus.out_data),  32'd0);
    chk("mrst_ch",    32'(bus.out_ch),    32'd0);
    chk("mrst_drop",  32'(bus.drop),      32'd0);
    chk("mrst_ptr",   32'(dut.ptr),       32'd0);
    chk("mrst_dcnt",  32'(dut.dcnt),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
